// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter slice
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period divider, restartable via clear_i
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   clear_i restart the count at zero on the next cycle
//   tick_o  high on the terminal count (last cycle of a bit period)
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk_i)
    cnt_q <= (rst_i || clear_i || tick_o) ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/uart_tx_wb.sv
// uart_tx_wb: Wishbone classic sink that serialises written bytes onto a UART TX line
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   cyc_i   Wishbone cycle valid
//   stb_i   Wishbone strobe
//   we_i    write enable
//   dat_i   byte to transmit
//   ack_o   single-cycle acknowledge
//   stall_o busy while a frame is on the line
//   tx_o    UART serial output, idle high
module uart_tx_wb
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  output logic       stall_o,
  output logic       tx_o
);
  uart_tx_state_t state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0] bit_q;
  logic stop_q;
  logic ack_q;
  logic tx_q;
  logic req_ok;
  logic accept;
  logic tick;
  // the !ack_q term keeps a held request from being acked on consecutive cycles
  assign req_ok = cyc_i && stb_i && state_q == IDLE && !ack_q;
  assign accept = req_ok && we_i;
  assign stall_o = state_q != IDLE;
  assign ack_o = ack_q;
  assign tx_o = tx_q;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (accept),
    .tick_o  (tick)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      ack_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      ack_q <= req_ok;
      case (state_q)
        IDLE: if (accept) begin
          shift_q <= dat_i;
          state_q <= START;
          tx_q    <= 1'b0;
        end
        START: if (tick) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
        end
        // tx is registered, so the next bit to drive is shift_q[1] before the shift lands
        DATA: if (tick) begin
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else
            tx_q <= shift_q[1];
        end
        STOP: if (tick) begin
          stop_q <= stop_q + 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_wb.sv
// tb_uart_tx_wb: directed self-checking bench for uart_tx_wb with 1 and 2 stop bits
module tb_uart_tx_wb;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc1 = 1'b0;
  logic cyc2 = 1'b0;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic [7:0] dat = 8'h00;
  logic sel = 1'b0;
  logic ack1, stall1, tx1, ack2, stall2, tx2;
  logic ack, stall, tx;
  int tests = 0;
  int fails = 0;
  assign ack = sel ? ack2 : ack1;
  assign stall = sel ? stall2 : stall1;
  assign tx = sel ? tx2 : tx1;
  always #5 clk = ~clk;
  uart_tx_wb #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc1), .stb_i(stb), .we_i(we),
    .dat_i(dat), .ack_o(ack1), .stall_o(stall1), .tx_o(tx1)
  );
  uart_tx_wb #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc2), .stb_i(stb), .we_i(we),
    .dat_i(dat), .ack_o(ack2), .stall_o(stall2), .tx_o(tx2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    return k == 0 ? 1'b0 : k <= 8 ? b[k-1] : 1'b1;
  endfunction
  task automatic drop();
    cyc1 = 1'b0;
    cyc2 = 1'b0;
    stb = 1'b0;
    we = 1'b0;
  endtask
  task automatic request(input logic w, input logic [7:0] b);
    @(negedge clk);
    cyc1 = !sel;
    cyc2 = sel;
    stb = 1'b1;
    we = w;
    dat = b;
  endtask
  task automatic idle_check(input string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_ack"}, ack, 0);
  endtask
  task automatic expect_frame(input logic [7:0] b, input int nstop, input logic keep, input logic [7:0] nxt);
    int n;
    n = (9 + nstop) * CPB;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("frame_tx", tx, exp_bit(b, i));
      check("frame_stall", stall, 1);
      check("frame_ack", ack, i == 0);
      if (i == 0) begin
        if (keep) dat = nxt;
        else drop();
      end
    end
    @(negedge clk);
    idle_check("frame_end");
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_check("reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_check("idle");
    end
    request(1'b1, 8'hA5);
    expect_frame(8'hA5, 1, 1'b1, 8'h3C);
    expect_frame(8'h3C, 1, 1'b0, 8'h00);
    sel = 1'b1;
    request(1'b1, 8'hFF);
    expect_frame(8'hFF, 2, 1'b0, 8'h00);
    sel = 1'b0;
    request(1'b1, 8'h00);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("mid_tx", tx, exp_bit(8'h00, i));
      check("mid_ack", ack, i == 0);
      if (i == 0) drop();
    end
    rst = 1'b1;
    @(negedge clk);
    idle_check("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_check("post_rst");
    end
    request(1'b1, 8'h81);
    expect_frame(8'h81, 1, 1'b0, 8'h00);
    request(1'b0, 8'h55);
    @(negedge clk);
    check("read_ack", ack, 1);
    check("read_tx", tx, 1);
    check("read_stall", stall, 0);
    drop();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_check("read_after");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
